// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM dead-time slice: FSM state encoding and the
// default width of the dead-time counters.
package pwm_pkg;

   localparam int DT_WIDTH_DEFAULT = 8;

   typedef logic [2:0] pwm_state_t;

   localparam pwm_state_t ST_OFF     = 3'd0;
   localparam pwm_state_t ST_DT_RISE = 3'd1;
   localparam pwm_state_t ST_H_ON    = 3'd2;
   localparam pwm_state_t ST_DT_FALL = 3'd3;
   localparam pwm_state_t ST_L_ON    = 3'd4;
   localparam pwm_state_t ST_FAULT   = 3'd5;

   function automatic logic is_dead_band(input pwm_state_t s);
      return (s == ST_DT_RISE) || (s == ST_DT_FALL);
   endfunction

endpackage

// File: rtl/pwm_dt_counter.sv
// Loadable down-counter that times one dead band; done marks the last
// dead-band cycle so the FSM leaves the band exactly on time.
module pwm_dt_counter
   import pwm_pkg::*;
#(
   parameter int WIDTH = DT_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic [WIDTH-1:0] value,
   output logic             done
);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (dec && (value != '0)) begin
         value <= value - WIDTH'(1);
      end
   end

   assign done = (value == WIDTH'(1));

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive generator inserting dead bands around each PWM edge.
// Define PWM_DT_FAULT_EN to add the i_fault / i_fault_clr / o_fault latch.
module pwm_deadtime
   import pwm_pkg::*;
#(
   parameter int DT_WIDTH = DT_WIDTH_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                dt_EN,
   input  logic                i_pwm,
   input  logic [DT_WIDTH-1:0] rise_dt,
   input  logic [DT_WIDTH-1:0] fall_dt,
   output logic                o_pwm_h,
   output logic                o_pwm_l,
   output logic                o_dt_active
`ifdef PWM_DT_FAULT_EN
   ,
   input  logic                i_fault,
   input  logic                i_fault_clr,
   output logic                o_fault
`endif
);

   pwm_state_t          state, next_state;
   logic                pwm_q, rise_edge, fall_edge;
   logic                fault_req, fault_clr;
   logic                go_rise, go_fall;
   logic                cnt_clear, cnt_load, cnt_dec, cnt_done;
   logic [DT_WIDTH-1:0] cnt_load_val, cnt_value;

`ifdef PWM_DT_FAULT_EN
   assign fault_req = i_fault;
   assign fault_clr = i_fault_clr & ~i_fault;
`else
   assign fault_req = 1'b0;
   assign fault_clr = 1'b0;
`endif

   assign rise_edge = i_pwm & ~pwm_q;
   assign fall_edge = ~i_pwm & pwm_q;

   // A fresh edge always restarts the band, so pulses shorter than it vanish.
   always_comb begin
      next_state   = state;
      cnt_clear    = 1'b0;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;
      go_rise      = 1'b0;
      go_fall      = 1'b0;

      if (fault_req) begin
         next_state = ST_FAULT;
         cnt_clear  = 1'b1;
      end else if (state == ST_FAULT) begin
         if (!fault_clr) begin
            cnt_clear = 1'b1;
         end else if (!dt_EN) begin
            next_state = ST_OFF;
            cnt_clear  = 1'b1;
         end else begin
            go_rise = i_pwm;
            go_fall = ~i_pwm;
         end
      end else if (!dt_EN) begin
         next_state = ST_OFF;
         cnt_clear  = 1'b1;
      end else begin
         case (state)
            ST_OFF: begin
               go_rise = i_pwm;
               go_fall = ~i_pwm;
            end
            ST_DT_RISE: begin
               if (fall_edge)                        go_fall    = 1'b1;
               else if (cnt_done || cnt_value == '0) next_state = ST_H_ON;
               else                                  cnt_dec    = 1'b1;
            end
            ST_H_ON:    if (fall_edge) go_fall = 1'b1;
            ST_DT_FALL: begin
               if (rise_edge)                        go_rise    = 1'b1;
               else if (cnt_done || cnt_value == '0) next_state = ST_L_ON;
               else                                  cnt_dec    = 1'b1;
            end
            ST_L_ON:    if (rise_edge) go_rise = 1'b1;
            default:    next_state = ST_OFF;
         endcase
      end

      // A zero dead time skips the band and drives the target side at once.
      if (go_rise) begin
         if (rise_dt == '0) begin
            next_state = ST_H_ON;
         end else begin
            next_state   = ST_DT_RISE;
            cnt_load     = 1'b1;
            cnt_load_val = rise_dt;
         end
      end else if (go_fall) begin
         if (fall_dt == '0) begin
            next_state = ST_L_ON;
         end else begin
            next_state   = ST_DT_FALL;
            cnt_load     = 1'b1;
            cnt_load_val = fall_dt;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_OFF;
         pwm_q       <= 1'b0;
         o_pwm_h     <= 1'b0;
         o_pwm_l     <= 1'b0;
         o_dt_active <= 1'b0;
      end else begin
         state       <= next_state;
         pwm_q       <= i_pwm;
         o_pwm_h     <= (next_state == ST_H_ON);
         o_pwm_l     <= (next_state == ST_L_ON);
         o_dt_active <= is_dead_band(next_state);
      end
   end

`ifdef PWM_DT_FAULT_EN
   always_ff @(posedge clk) begin
      if (rst) o_fault <= 1'b0;
      else     o_fault <= (next_state == ST_FAULT);
   end
`endif

   pwm_dt_counter #(
      .WIDTH(DT_WIDTH)
   ) u_counter (
      .clk      (clk),
      .rst      (rst),
      .clear    (cnt_clear),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .value    (cnt_value),
      .done     (cnt_done)
   );

endmodule

// File: doc/pwm_deadtime.md
PWM_DEADTIME -- requirements
Module: pwm_deadtime

Interface
REQ-001 Parameter DT_WIDTH, default 8, width of the dead-time count registers.
REQ-002 clk  input  1  system clock; all logic on the rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 dt_EN  input  1  block enable; low forces both outputs low.
REQ-005 i_pwm  input  1  raw PWM from the upstream PWM core (its o_pwm).
REQ-006 rise_dt  input  DT_WIDTH  dead-band cycles inserted before o_pwm_h asserts.
REQ-007 fall_dt  input  DT_WIDTH  dead-band cycles inserted before o_pwm_l asserts.
REQ-008 o_pwm_h  output  1  high-side gate drive, registered.
REQ-009 o_pwm_l  output  1  low-side gate drive, registered.
REQ-010 o_dt_active  output  1  high while in a dead band, registered.

Function
REQ-011 FSM states: OFF, DT_RISE, H_ON, DT_FALL, L_ON (plus FAULT, see REQ-026).
REQ-012 Outputs per state: OFF/DT_RISE/DT_FALL give h=0, l=0; H_ON gives h=1, l=0; L_ON gives h=0, l=1; o_dt_active=1 only in DT_RISE/DT_FALL.
REQ-013 i_pwm is registered once (pwm_q); a rising edge = i_pwm=1 & pwm_q=0; a falling edge = i_pwm=0 & pwm_q=1.
REQ-014 Rising edge seen in cycle N from L_ON: o_pwm_l low at N+1; o_pwm_h high at N+1+rise_dt.
REQ-015 Falling edge seen in cycle N from H_ON: o_pwm_h low at N+1; o_pwm_l high at N+1+fall_dt.
REQ-016 rise_dt=0 or fall_dt=0: direct transition with no dead band; o_dt_active stays 0.
REQ-017 The dead-time counter loads rise_dt/fall_dt on entry to DT_RISE/DT_FALL; later changes to rise_dt/fall_dt do not affect the running count.
REQ-018 Falling edge during DT_RISE: go to DT_FALL and reload fall_dt; rising edge during DT_FALL: go to DT_RISE and reload rise_dt; pulses narrower than the dead time are swallowed.
REQ-019 dt_EN low: next cycle state=OFF, both outputs low, counter cleared.
REQ-020 dt_EN rising while in OFF: i_pwm=1 enters DT_RISE, i_pwm=0 enters DT_FALL; every enable therefore starts with a dead band.
REQ-021 Invariant: o_pwm_h and o_pwm_l are never 1 in the same cycle under any input sequence.

Reset
REQ-022 rst=1 at a clock edge: state=OFF, pwm_q=0, counter=0, o_pwm_h=0, o_pwm_l=0, o_dt_active=0.
REQ-023 rst has priority over dt_EN, edges and fault; reset mid-dead-band aborts the count.
REQ-024 After rst release, the block behaves per REQ-020, taking dt_EN as the enable event.

Configuration
REQ-025 Macro PWM_DT_FAULT_EN; when defined, the block adds ports i_fault (input, 1), i_fault_clr (input, 1) and o_fault (output, 1, registered).
REQ-026 With the macro: i_fault=1 sends the FSM to FAULT the next cycle from any state; FAULT gives h=0, l=0 and o_fault=1.
REQ-027 Exit from FAULT only when i_fault=0 and i_fault_clr=1; exit follows the REQ-020 dead-band entry.
REQ-028 Without the macro: the fault ports are absent and the FAULT state is unreachable.

Structure
REQ-029 Shared package pwm_pkg holds the FSM state typedef and the DT_WIDTH default constant.
REQ-030 One sub-module, pwm_dt_counter: loadable down-counter with load, value and done outputs.

Verification
REQ-031 Enable at dt=0 with PWM from pwm_core (period 100, duty 25), rise_dt=5, fall_dt=3 -> h high 25-5 cycles per period; l high 75-3 cycles per period.
REQ-032 rise_dt=fall_dt=0 -> h equals i_pwm and l equals ~i_pwm, each delayed 1 cycle.
REQ-033 i_pwm pulse of 3 cycles with rise_dt=8 -> h stays 0; l goes low for 3+fall_dt cycles, then high.
REQ-034 dt_EN low for 200 cycles mid-H_ON -> both outputs 0 from the next cycle; re-enable gives a dead band before either output asserts.
REQ-035 rst asserted during DT_FALL -> all outputs 0 next cycle; assertion fails if h&l is ever 1 across all random i_pwm/rise_dt/fall_dt runs.
REQ-036 With PWM_DT_FAULT_EN: i_fault pulse in H_ON -> h=0 next cycle with o_fault=1; o_fault holds until i_fault_clr, then a fall_dt band precedes l.
